axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4 responder (subordinate) memory model for the other end of the core's fetch and load/store AXI ports.
- Read channel accepts INCR bursts (icache line fills) and single beats (LSU loads); write channel accepts single-beat strobed stores.
- Sits behind the core in the simulation top and in the FPGA bring-up shell, backed by an internal word-addressed array.

Parameters:
- MEM_WORDS, 65536, depth of the 32-bit storage array.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LATENCY, 2, cycles from the AR handshake to the first rvalid; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- arvalid in 1 / arready out 1  read address handshake
- araddr  in  32  read byte address
- arburst in  2  burst type; 2'b01 INCR is the only supported type
- arlen   in  8  beats minus 1
- arsize  in  3  bytes per beat as log2; values 0..2 are legal
- rvalid out 1 / rready in 1  read data handshake
- rdata   out  32  read data
- rresp   out  2  read response: 00 OKAY, 10 SLVERR, 11 DECERR
- rlast   out  1  final beat of the burst
- awvalid in 1 / awready out 1  write address handshake
- awaddr  in  32  write byte address
- wvalid in 1 / wready out 1  write data handshake
- wdata   in  32  write data
- wstrb   in  4  byte enables
- bvalid out 1 / bready in 1  write response handshake
- bresp   out  2  write response code

Behaviour:
- Reset, while reset==0:
  - rvalid, rlast, bvalid, awready, wready, arready = 0; rdata = 0; rresp = bresp = 0.
  - FSMs go to idle.
  - Array contents are NOT reset.
  - After release, arready, awready and wready rise the next cycle.
- Read FSM states: R_IDLE, R_WAIT, R_BEAT.
  - R_IDLE: arready=1. On arvalid&&arready, latch addr, len, size and burst; load the latency counter with READ_LATENCY-1; go to R_WAIT.
  - R_WAIT: count down; at 0 go to R_BEAT. Load rdata/rresp from the current address and raise rvalid.
  - R_BEAT: rdata/rresp/rlast are held stable while rvalid&&!rready. On rvalid&&rready:
    - if the beat counter equals len, drop rvalid and return to R_IDLE (arready rises the next cycle);
    - otherwise addr += (1<<size) and present the next beat the following cycle. Back-to-back beats are allowed while rready is held.
  - rlast = 1 only on beat index == len; a len=0 burst has rlast on its single beat.
- Read response codes:
  - arburst != INCR, or arsize > 2: every beat returns SLVERR with rdata=0. Beat count still honours arlen.
  - Beat address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS): that beat returns DECERR with rdata=0. This check is per beat, so a burst running off the end returns OKAY beats then DECERR beats.
  - rdata is always the full aligned word; the core extracts bytes itself.
- Write channel:
  - AW and W are captured independently. awready is high until AW is held; wready is high until W is held. Either order, or both in the same cycle, is legal.
  - When both are held: perform the strobed byte write (no write on DECERR), then raise bvalid with bresp (OKAY, or DECERR if out of range). awready and wready stay 0 while bvalid.
  - On bvalid&&bready: clear bvalid and the held flags; the readies rise the next cycle.
- Simultaneous read and write to the same word: a read beat sampled in the same cycle as the array write returns the old data.
- No ordering is enforced between the read and write channels.
- Index arithmetic: index = (addr - BASE_ADDR) >> 2, truncated to clog2(MEM_WORDS) bits after the range check.

Optional Feature:
- AXI_SRAM_RAND_DELAY_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, applied at reset) adds 0..3 stall cycles. The stalls apply before each R_BEAT beat and before bvalid rises; the stall count is the LFSR's low 2 bits, and the LFSR steps every cycle.
- Undefined: fixed timing exactly as in Behaviour.

Decomposition:
- Shared package `axi_pkg`:
  - constants AXI_RESP_OKAY/SLVERR/DECERR and AXI_BURST_FIXED/INCR/WRAP;
  - read and write FSM state encodings.
- One sub-module: `axi_sram_lfsr` (16-bit LFSR with enable, seed and step), instantiated only under AXI_SRAM_RAND_DELAY_EN.

Test Plan:
- Preload word 0x8000_0010=0x1234_5678; single read, araddr=0x8000_0010, len=0, size=2 -> rvalid after 2 cycles, rdata=0x1234_5678, rresp=00, rlast=1.
- INCR read, araddr=0x8000_0000, len=3, size=2, rready toggling 1,0,1,0 -> 4 beats from words 0..3, data stable during stalls, rlast only on beat 4.
- Write data 0xAABBCCDD with wstrb=4'b0101 (W accepted 3 cycles before AW) over 0x1111_1111 at 0x8000_0020 -> bresp=00; read-back returns 0x11BB11DD.
- Read at araddr=0x7FFF_FFFC -> DECERR, rdata=0.
- Burst with arburst=2'b10 -> all beats SLVERR.
- Burst of len=1 starting at the last word -> beat 1 OKAY, beat 2 DECERR.
- Drive reset low during beat 2 of a len=7 burst -> rvalid=0 immediately; after release arready=1, and a new read returns correct data with memory unchanged.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state encodings for the SRAM responder.
// Contents: response codes, burst types, read/write FSM states.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BEAT
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STALL,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/axi_sram_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random stall timing.
// Ports: clock, reset (async active-low, loads SEED), en (step), q (state).
module axi_sram_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a word array: INCR read bursts, single strobed writes.
// Ports: clock/reset, AR/R and AW/W/B channels. Option: AXI_SRAM_RAND_DELAY_EN.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter int          MEM_WORDS    = 65536,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int          IW     = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN   = 32'(4 * MEM_WORDS);
    localparam logic [7:0]  LAT_M1 = 8'(READ_LATENCY - 1);

    logic [31:0] mem [MEM_WORDS];
    logic        live;
    logic [1:0]  stall;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    axi_sram_lfsr #(.SEED(16'hACE1)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    assign stall = lfsr_q[1:0];
`else
    assign stall = 2'd0;
`endif

    function automatic logic hit(input logic [31:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IW-1:0] idx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [1:0] resp_of(
        input logic [31:0] a,
        input logic [1:0]  b,
        input logic [2:0]  s
    );
        if (b != AXI_BURST_INCR || s > 3'd2) return AXI_RESP_SLVERR;
        if (!hit(a)) return AXI_RESP_DECERR;
        return AXI_RESP_OKAY;
    endfunction

    // Readies are held low for the first cycle after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------- read channel ----------------
    r_state_t    r_state, r_state_d;
    logic [31:0] r_addr, r_addr_d;
    logic [7:0]  r_len, r_len_d;
    logic [2:0]  r_size, r_size_d;
    logic [1:0]  r_burst, r_burst_d;
    logic [7:0]  r_cnt, r_cnt_d;
    logic [7:0]  r_beat, r_beat_d;
    logic        rvalid_d, rlast_d;
    logic [31:0] rdata_d;
    logic [1:0]  rresp_d;
    logic        r_load;

    assign arready = live && (r_state == R_IDLE);

    always_comb begin
        r_state_d = r_state;
        r_addr_d  = r_addr;
        r_len_d   = r_len;
        r_size_d  = r_size;
        r_burst_d = r_burst;
        r_cnt_d   = r_cnt;
        r_beat_d  = r_beat;
        rvalid_d  = rvalid;
        rlast_d   = rlast;
        rdata_d   = rdata;
        rresp_d   = rresp;
        r_load    = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_cnt_d   = LAT_M1 + 8'(stall);
                    r_beat_d  = 8'd0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt == 8'd0) begin
                    r_load    = 1'b1;
                    r_state_d = R_BEAT;
                end else begin
                    r_cnt_d = r_cnt - 8'd1;
                end
            end
            R_BEAT: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (r_beat == r_len) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_addr + (32'd1 << r_size);
                        r_beat_d = r_beat + 8'd1;
                        if (stall == 2'd0) begin
                            r_load = 1'b1;
                        end else begin
                            r_cnt_d   = 8'(stall) - 8'd1;
                            r_state_d = R_WAIT;
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Beat data is sampled from the array here, before any same-cycle write.
        if (r_load) begin
            rvalid_d = 1'b1;
            rlast_d  = (r_beat_d == r_len_d);
            rresp_d  = resp_of(r_addr_d, r_burst_d, r_size_d);
            rdata_d  = (rresp_d == AXI_RESP_OKAY) ? mem[idx(r_addr_d)] : 32'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            r_addr  <= 32'd0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= 2'd0;
            r_cnt   <= 8'd0;
            r_beat  <= 8'd0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= 2'd0;
        end else begin
            r_state <= r_state_d;
            r_addr  <= r_addr_d;
            r_len   <= r_len_d;
            r_size  <= r_size_d;
            r_burst <= r_burst_d;
            r_cnt   <= r_cnt_d;
            r_beat  <= r_beat_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rdata   <= rdata_d;
            rresp   <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_state_d;
    logic        aw_held, aw_held_d;
    logic        w_held, w_held_d;
    logic [31:0] aw_addr, aw_addr_d;
    logic [31:0] w_data, w_data_d;
    logic [3:0]  w_strb, w_strb_d;
    logic [1:0]  w_cnt, w_cnt_d;
    logic        bvalid_d;
    logic [1:0]  bresp_d;
    logic        commit, mem_we;

    assign awready = live && !aw_held && (w_state == W_IDLE);
    assign wready  = live && !w_held && (w_state == W_IDLE);

    always_comb begin
        w_state_d = w_state;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        aw_addr_d = aw_addr;
        w_data_d  = w_data;
        w_strb_d  = w_strb;
        w_cnt_d   = w_cnt;
        bvalid_d  = bvalid;
        bresp_d   = bresp;
        commit    = 1'b0;
        mem_we    = 1'b0;
        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        unique case (w_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    if (stall == 2'd0) begin
                        commit = 1'b1;
                    end else begin
                        w_cnt_d   = stall - 2'd1;
                        w_state_d = W_STALL;
                    end
                end
            end
            W_STALL: begin
                if (w_cnt == 2'd0) commit = 1'b1;
                else               w_cnt_d = w_cnt - 2'd1;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit) begin
            mem_we    = hit(aw_addr);
            bvalid_d  = 1'b1;
            bresp_d   = mem_we ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            w_state_d = W_RESP;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= 32'd0;
            w_data  <= 32'd0;
            w_strb  <= 4'd0;
            w_cnt   <= 2'd0;
            bvalid  <= 1'b0;
            bresp   <= 2'd0;
        end else begin
            w_state <= w_state_d;
            aw_held <= aw_held_d;
            w_held  <= w_held_d;
            aw_addr <= aw_addr_d;
            w_data  <= w_data_d;
            w_strb  <= w_strb_d;
            w_cnt   <= w_cnt_d;
            bvalid  <= bvalid_d;
            bresp   <= bresp_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: reference word model, queued beats.
// Drives AR/AW/W from tasks, checks R/B beats in a negedge monitor.
module tb_axi_sram_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] LIMIT = 32'h8004_0000;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    bit          rr_tog = 0;
    beat_t       rq[$];
    logic [1:0]  bq[$];
    logic [31:0] model [logic [31:0]];

    axi_sram_responder dut (
        .clock   (clock),
        .reset   (reset),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arburst (arburst),
        .arlen   (arlen),
        .arsize  (arsize),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            rready = rr_tog ? ~rready : 1'b1;
        end
    end

    // Beats are compared on every rvalid cycle so held data is checked too.
    always @(negedge clock) begin
        if (rvalid) begin
            if (rq.size() == 0) begin
                chk("r_unexp", {31'd0, rvalid}, 32'd0);
            end else begin
                chk("rdata", rdata, rq[0].d);
                chk("rresp", {30'd0, rresp}, {30'd0, rq[0].r});
                chk("rlast", {31'd0, rlast}, {31'd0, rq[0].l});
                if (rready) begin
                    void'(rq.pop_front());
                    pops++;
                end
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                chk("b_unexp", {31'd0, bvalid}, 32'd0);
            end else begin
                chk("bresp", {30'd0, bresp}, {30'd0, bq.pop_front()});
            end
        end
    end

    function automatic void exp_beat(input logic [31:0] a,
                                     input logic [2:0] sz,
                                     input logic [1:0] bu,
                                     input logic last);
        beat_t       e;
        logic [31:0] k;
        k   = a & ~32'h3;
        e.l = last;
        if (bu != 2'b01 || sz > 3'd2) begin
            e.d = 32'd0;
            e.r = 2'b10;
        end else if (a < BASE || a >= LIMIT) begin
            e.d = 32'd0;
            e.r = 2'b11;
        end else begin
            e.r = 2'b00;
            e.d = model.exists(k) ? model[k] : 32'd0;
        end
        rq.push_back(e);
    endfunction

    task automatic axi_read(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu,
                            input bit lat, input bit drain);
        int n;
        bit hs;
        for (int i = 0; i <= int'(len); i++) begin
            exp_beat(a + (32'(i) << sz), sz, bu, i == int'(len));
        end
        arvalid = 1'b1;
        araddr  = a;
        arlen   = len;
        arsize  = sz;
        arburst = bu;
        n  = 0;
        hs = 0;
        while (!hs && n < 50) begin
            @(negedge clock);
            hs = arready;
            @(posedge clock);
            #1;
            n++;
        end
        arvalid = 1'b0;
        chk("ar_hs", {31'd0, hs}, 32'd1);
        if (lat) begin
            n = 0;
            @(negedge clock);
            while (!rvalid && n < 20) begin
                @(posedge clock);
                n++;
                @(negedge clock);
            end
`ifndef AXI_SRAM_RAND_DELAY_EN
            chk("r_latency", 32'(n), 32'd2);
`endif
        end
        if (drain) begin
            n = 0;
            while (rq.size() != 0 && n < 300) begin
                @(negedge clock);
                #1;
                n++;
            end
            chk("r_drain", 32'(rq.size()), 32'd0);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int gap);
        int          n;
        int          wc;
        bit          wh, ah, aw_pend;
        logic [31:0] k, v;
        k = a & ~32'h3;
        if (a >= BASE && a < LIMIT) begin
            v = model.exists(k) ? model[k] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            end
            model[k] = v;
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b11);
        end
        wvalid  = 1'b1;
        wdata   = d;
        wstrb   = s;
        awaddr  = a;
        aw_pend = 1;
        wc      = gap;
        if (gap == 0) awvalid = 1'b1;
        n = 0;
        while ((wvalid || aw_pend) && n < 100) begin
            @(negedge clock);
            wh = wvalid && wready;
            ah = awvalid && awready;
            @(posedge clock);
            #1;
            n++;
            if (wh) wvalid = 1'b0;
            if (ah) begin
                awvalid = 1'b0;
                aw_pend = 0;
            end
            if (!wvalid && aw_pend && !awvalid) begin
                if (wc <= 1) awvalid = 1'b1;
                else wc--;
            end
        end
        chk("aw_w_hs", {31'd0, wvalid || aw_pend}, 32'd0);
        n = 0;
        while (bq.size() != 0 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("b_drain", 32'(bq.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          p0;
        logic [31:0] a;
        logic [2:0]  sz;
        reset   = 1'b0;
        arvalid = 1'b0;
        araddr  = 32'd0;
        arburst = 2'b01;
        arlen   = 8'd0;
        arsize  = 3'd2;
        awvalid = 1'b0;
        awaddr  = 32'd0;
        wvalid  = 1'b0;
        wdata   = 32'd0;
        wstrb   = 4'd0;
        bready  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("arready_lag", {31'd0, arready}, 32'd0);
        @(posedge clock);
        #1;
        chk("arready_up", {31'd0, arready}, 32'd1);
        chk("awready_up", {31'd0, awready}, 32'd1);
        chk("wready_up", {31'd0, wready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            axi_write(BASE + 32'(4 * i),
                      (i == 4) ? 32'h1234_5678 : 32'hC0DE_0000 + 32'(i * 273),
                      4'hF, i % 3);
        end
        axi_write(32'h8000_0020, 32'h1111_1111, 4'hF, 0);
        axi_write(32'h8003_FFFC, 32'hDEAD_BEEF, 4'hF, 1);

        axi_read(32'h8000_0010, 8'd0, 3'd2, 2'b01, 1, 1);

        rr_tog = 1;
        axi_read(32'h8000_0000, 8'd3, 3'd2, 2'b01, 0, 1);
        rr_tog = 0;

        axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 3);
        axi_read(32'h8000_0020, 8'd0, 3'd2, 2'b01, 0, 1);

        axi_read(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 0, 1);
        axi_read(32'h8000_0000, 8'd2, 3'd2, 2'b10, 0, 1);
        axi_read(32'h8000_0004, 8'd0, 3'd3, 2'b01, 0, 1);
        axi_read(32'h8003_FFFC, 8'd1, 3'd2, 2'b01, 0, 1);

        axi_write(32'h9000_0000, 32'h5555_5555, 4'hF, 0);
        axi_write(32'h8000_0008, 32'h0000_EE00, 4'b0010, 2);

        for (int k = 0; k < 6; k++) begin
            sz = 3'($urandom_range(0, 2));
            a  = BASE + 32'(4 * $urandom_range(0, 7));
            if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
            if (sz == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
            axi_read(a, 8'd1, sz, 2'b01, 0, 1);
        end

        p0 = pops;
        axi_read(32'h8000_0000, 8'd7, 3'd2, 2'b01, 0, 0);
        n = 0;
        while (pops < p0 + 1 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("beat1_seen", 32'(pops - p0), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_rst_arready", {31'd0, arready}, 32'd0);
        rq.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_arready", {31'd0, arready}, 32'd1);
        axi_read(32'h8000_0010, 8'd1, 3'd2, 2'b01, 1, 1);
        axi_read(32'h8000_0000, 8'd3, 3'd2, 2'b01, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
